// File: rtl/ad9361_seq_pkg.sv
// Shared types and default timing for the AD9361 reset / multi-chip-sync sequencer.
// The state encoding is visible to software through the debug state port.
package ad9361_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_HOLD   = 3'd1,
    ST_PWR_WAIT   = 3'd2,
    ST_READY      = 3'd3,
    ST_SYNC_ALIGN = 3'd4,
    ST_SYNC_PULSE = 3'd5,
    ST_SYNC_GAP   = 3'd6,
    ST_FAULT      = 3'd7
  } state_e;

  localparam int DEF_RESET_HOLD_CYCLES  = 1000;
  localparam int DEF_POWERUP_CYCLES     = 65536;
  localparam int DEF_SYNC_PULSE_CYCLES  = 4;
  localparam int DEF_SYNC_GAP_CYCLES    = 64;
  localparam int DEF_REF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CNT_W              = 24;

  function automatic logic is_busy_state(state_e s);
    return s inside {ST_RST_HOLD, ST_PWR_WAIT, ST_SYNC_ALIGN, ST_SYNC_PULSE, ST_SYNC_GAP};
  endfunction

endpackage

// File: rtl/ad9361_mcs_sequencer_if.sv
// Software GPIO side and transceiver control pins of the sequencer, bundled as one interface.
// slave is the sequencer's view; master is the software / board view.
interface ad9361_mcs_sequencer_if;

  logic       start;
  logic       sync_req;
  logic [3:0] sync_count;
  logic       ref_clk_in;
  logic       resetb_0;
  logic       resetb_1;
  logic       mcs_sync;
  logic       busy;
  logic       ready;
  logic       error;
  logic [2:0] state;

  modport slave (
    input  start, sync_req, sync_count, ref_clk_in,
    output resetb_0, resetb_1, mcs_sync, busy, ready, error, state
  );

  modport master (
    output start, sync_req, sync_count, ref_clk_in,
    input  resetb_0, resetb_1, mcs_sync, busy, ready, error, state
  );

endinterface

// File: rtl/ad9361_mcs_sequencer_ref_edge_sync.sv
// Three-flop synchroniser for the asynchronous reference clock with a registered
// one-cycle pulse on each detected rising edge (stage2 high, stage3 low).
module ref_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ref_clk_i,
  output logic edge_o
);

  logic [2:0] sync_q;
  logic       edge_q;

  // NOTE: non-blocking assignments so each stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], ref_clk_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/ad9361_mcs_sequencer.sv
// Drives both AD9361 resetb lines, waits for power-up, then issues the programmed
// number of MCS pulses, each aligned to a rising edge of the shared reference clock.
module ad9361_mcs_sequencer
  import ad9361_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int POWERUP_CYCLES     = DEF_POWERUP_CYCLES,
  parameter int SYNC_PULSE_CYCLES  = DEF_SYNC_PULSE_CYCLES,
  parameter int SYNC_GAP_CYCLES    = DEF_SYNC_GAP_CYCLES,
  parameter int REF_TIMEOUT_CYCLES = DEF_REF_TIMEOUT_CYCLES,
  parameter int CNT_W              = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  ad9361_mcs_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] RH_LOAD  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SP_LOAD  = CNT_W'(SYNC_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SG_LOAD  = CNT_W'(SYNC_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(REF_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       remain_q, remain_d;
  logic             resetb_q, resetb_d;
  logic             mcs_sync_q, mcs_sync_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic             ref_edge;
  logic             cnt_done;

  ref_edge_sync u_ref_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .ref_clk_i (bus.ref_clk_in),
    .edge_o    (ref_edge)
  );

  assign cnt_done = (cnt_q == '0);

  // NOTE: every signal gets its default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_done ? cnt_q : cnt_q - CNT_ONE;
    remain_d = remain_q;

    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (bus.start) begin
          remain_d = bus.sync_count;
          state_d  = ST_RST_HOLD;
          cnt_d    = RH_LOAD;
        end
      end
      ST_RST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_PWR_WAIT;
          cnt_d   = PW_LOAD;
        end
      end
      ST_PWR_WAIT: begin
        if (cnt_done) begin
          if (remain_q == 4'd0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_SYNC_ALIGN;
            cnt_d   = TO_LOAD;
          end
        end
      end
      ST_READY: begin
        if (bus.start) begin
          remain_d = bus.sync_count;
          state_d  = ST_RST_HOLD;
          cnt_d    = RH_LOAD;
        end else if (bus.sync_req) begin
          remain_d = bus.sync_count;
          if (bus.sync_count != 4'd0) begin
            state_d = ST_SYNC_ALIGN;
            cnt_d   = TO_LOAD;
          end
        end
      end
      ST_SYNC_ALIGN: begin
        // An edge arriving in the expiry cycle still counts as aligned.
        if (ref_edge) begin
          state_d = ST_SYNC_PULSE;
          cnt_d   = SP_LOAD;
        end else if (cnt_done) begin
          state_d = ST_FAULT;
        end
      end
      ST_SYNC_PULSE: begin
        if (cnt_done) begin
          remain_d = (remain_q != 4'd0) ? remain_q - 4'd1 : 4'd0;
          if (remain_q <= 4'd1) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_SYNC_GAP;
            cnt_d   = SG_LOAD;
          end
        end
      end
      ST_SYNC_GAP: begin
        if (cnt_done) begin
          state_d = ST_SYNC_ALIGN;
          cnt_d   = TO_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    resetb_d   = !(state_d inside {ST_IDLE, ST_RST_HOLD});
    mcs_sync_d = (state_d == ST_SYNC_PULSE);
    busy_d     = is_busy_state(state_d);
    ready_d    = (state_d == ST_READY);
    error_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      remain_q   <= 4'd0;
      resetb_q   <= 1'b0;
      mcs_sync_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      remain_q   <= remain_d;
      resetb_q   <= resetb_d;
      mcs_sync_q <= mcs_sync_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  assign bus.resetb_0 = resetb_q;
  assign bus.resetb_1 = resetb_q;
  assign bus.mcs_sync = mcs_sync_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_ad9361_mcs_sequencer.sv
// Directed bench for ad9361_mcs_sequencer with short timing parameters and a 10-clk reference.
// Inputs change and outputs are checked on the falling clock edge.
module tb_ad9361_mcs_sequencer;
  import ad9361_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ad9361_mcs_sequencer_if bus ();

  ad9361_mcs_sequencer #(
    .RESET_HOLD_CYCLES  (8),
    .POWERUP_CYCLES     (16),
    .SYNC_PULSE_CYCLES  (4),
    .SYNC_GAP_CYCLES    (6),
    .REF_TIMEOUT_CYCLES (32),
    .CNT_W              (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running reference: 5 clk high, 5 clk low, changed on the falling edge.
  logic ref_run;
  int   ref_ph;
  always @(negedge clk) begin
    if (ref_run) begin
      ref_ph = (ref_ph == 9) ? 0 : ref_ph + 1;
      bus.ref_clk_in = (ref_ph < 5);
    end
  end

  // Pulse monitor: rise time relative to the ref sample edge E, width, gap since last fall.
  int cyc, last_ref_e, rise_cyc, fall_cyc, pulse_k;
  int delta_a [0:63];
  int width_a [0:63];
  int gap_a   [0:63];
  logic ref_prev, mcs_prev;
  always @(posedge clk) begin
    cyc++;
    if (bus.ref_clk_in === 1'b1 && !ref_prev) last_ref_e = cyc;
    ref_prev = (bus.ref_clk_in === 1'b1);
    #1;
    if (bus.mcs_sync === 1'b1 && !mcs_prev && pulse_k < 64) begin
      rise_cyc         = cyc;
      delta_a[pulse_k] = cyc - last_ref_e;
      gap_a[pulse_k]   = cyc - fall_cyc;
    end
    if (bus.mcs_sync !== 1'b1 && mcs_prev && pulse_k < 64) begin
      width_a[pulse_k] = cyc - rise_cyc;
      fall_cyc         = cyc;
      pulse_k++;
    end
    mcs_prev = (bus.mcs_sync === 1'b1);
  end

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_n(3);
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if ({bus.resetb_0, bus.resetb_1} !== 2'b00) begin n_bad++; $display("FAIL reset_resetb: got %b want 00", {bus.resetb_0, bus.resetb_1}); end
    n_cmp++; if ({bus.mcs_sync, bus.busy, bus.ready, bus.error} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus.mcs_sync, bus.busy, bus.ready, bus.error}); end
    rst = 1'b0;
    wait_n(2);
    n_cmp++; if (bus.state !== 3'd0 || bus.resetb_0 !== 1'b0) begin n_bad++; $display("FAIL idle_hold: got state %0d resetb %b want 0 0", bus.state, bus.resetb_0); end
  endtask

  task automatic test_full_no_sync();
    int k0;
    k0 = pulse_k;
    bus.start = 1'b1; bus.sync_count = 4'd0;
    wait_n(1);
    bus.start = 1'b0;
    n_cmp++; if (bus.state !== 3'd1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL nosync_enter: got state %0d busy %b want 1 1", bus.state, bus.busy); end
    wait_n(7);
    n_cmp++; if ({bus.resetb_0, bus.resetb_1} !== 2'b00) begin n_bad++; $display("FAIL nosync_hold_last: got %b want 00", {bus.resetb_0, bus.resetb_1}); end
    wait_n(1);
    n_cmp++; if ({bus.resetb_0, bus.resetb_1} !== 2'b11 || bus.state !== 3'd2) begin n_bad++; $display("FAIL nosync_release: got resetb %b state %0d want 11 2", {bus.resetb_0, bus.resetb_1}, bus.state); end
    wait_n(15);
    n_cmp++; if (bus.state !== 3'd2 || bus.ready !== 1'b0) begin n_bad++; $display("FAIL nosync_pwr_last: got state %0d ready %b want 2 0", bus.state, bus.ready); end
    wait_n(1);
    n_cmp++; if (bus.state !== 3'd3 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL nosync_ready: got state %0d ready %b busy %b want 3 1 0", bus.state, bus.ready, bus.busy); end
    n_cmp++; if (pulse_k != k0 || bus.mcs_sync !== 1'b0) begin n_bad++; $display("FAIL nosync_no_pulse: got %0d pulses want 0", pulse_k - k0); end
  endtask

  task automatic test_full_with_syncs();
    int k0, n;
    ref_run = 1'b1;
    k0 = pulse_k;
    bus.start = 1'b1; bus.sync_count = 4'd3;
    wait_n(1);
    bus.start = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin wait_n(1); n++; end
    n_cmp++; if (bus.ready !== 1'b1 || bus.state !== 3'd3) begin n_bad++; $display("FAIL syncs_ready: got ready %b state %0d want 1 3", bus.ready, bus.state); end
    n_cmp++; if (pulse_k - k0 != 3) begin n_bad++; $display("FAIL syncs_count: got %0d want 3", pulse_k - k0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (width_a[k0+i] != 4) begin n_bad++; $display("FAIL syncs_width%0d: got %0d want 4", i, width_a[k0+i]); end
      n_cmp++; if (delta_a[k0+i] != 3) begin n_bad++; $display("FAIL syncs_align%0d: got %0d want 3", i, delta_a[k0+i]); end
      if (i > 0) begin
        n_cmp++; if (gap_a[k0+i] < 7) begin n_bad++; $display("FAIL syncs_gap%0d: got %0d want >=7", i, gap_a[k0+i]); end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    ref_run = 1'b0;
    bus.ref_clk_in = 1'b0;
    wait_n(6);
    bus.sync_req = 1'b1; bus.sync_count = 4'd2;
    wait_n(1);
    bus.sync_req = 1'b0;
    n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL to_align: got %0d want 4", bus.state); end
    n = 1;
    while (bus.state === 3'd4 && n < 60) begin wait_n(1); n++; end
    n_cmp++; if (n != 33 || bus.state !== 3'd7) begin n_bad++; $display("FAIL to_fault_time: got step %0d state %0d want 33 7", n, bus.state); end
    n_cmp++; if (bus.error !== 1'b1 || bus.resetb_0 !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL to_fault_out: got err %b resetb %b busy %b want 1 1 0", bus.error, bus.resetb_0, bus.busy); end
    bus.sync_req = 1'b1; bus.sync_count = 4'd1;
    wait_n(1);
    bus.sync_req = 1'b0;
    wait_n(2);
    n_cmp++; if (bus.state !== 3'd7 || bus.error !== 1'b1) begin n_bad++; $display("FAIL to_req_ignored: got state %0d err %b want 7 1", bus.state, bus.error); end
    bus.start = 1'b1; bus.sync_count = 4'd0;
    wait_n(1);
    bus.start = 1'b0;
    n_cmp++; if (bus.state !== 3'd1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL to_recover: got state %0d err %b want 1 0", bus.state, bus.error); end
    wait_n(24);
    n_cmp++; if (bus.state !== 3'd3 || bus.ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got state %0d ready %b want 3 1", bus.state, bus.ready); end
  endtask

  task automatic test_simultaneous();
    bus.start = 1'b1; bus.sync_req = 1'b1; bus.sync_count = 4'd0;
    wait_n(1);
    bus.start = 1'b0; bus.sync_req = 1'b0;
    n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL simul_start_wins: got %0d want 1", bus.state); end
    wait_n(8);
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL simul_pwr: got %0d want 2", bus.state); end
    bus.sync_req = 1'b1; bus.sync_count = 4'd3;
    wait_n(1);
    bus.sync_req = 1'b0;
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL simul_req_ignored: got %0d want 2", bus.state); end
    wait_n(14);
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL simul_pwr_last: got %0d want 2", bus.state); end
    wait_n(1);
    n_cmp++; if (bus.state !== 3'd3 || bus.ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got state %0d ready %b want 3 1", bus.state, bus.ready); end
  endtask

  task automatic test_edge_at_expiry();
    int k0, n;
    k0 = pulse_k;
    bus.sync_req = 1'b1; bus.sync_count = 4'd1;
    wait_n(1);
    bus.sync_req = 1'b0;
    wait_n(28);
    bus.ref_clk_in = 1'b1;
    wait_n(3);
    n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL expiry_still_align: got %0d want 4", bus.state); end
    wait_n(1);
    n_cmp++; if (bus.state !== 3'd5 || bus.mcs_sync !== 1'b1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL expiry_edge_wins: got state %0d mcs %b err %b want 5 1 0", bus.state, bus.mcs_sync, bus.error); end
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin wait_n(1); n++; end
    n_cmp++; if (bus.ready !== 1'b1 || pulse_k - k0 != 1) begin n_bad++; $display("FAIL expiry_done: got ready %b pulses %0d want 1 1", bus.ready, pulse_k - k0); end
    bus.ref_clk_in = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    ref_run = 1'b1;
    bus.sync_req = 1'b1; bus.sync_count = 4'd2;
    wait_n(1);
    bus.sync_req = 1'b0;
    n = 0;
    while (bus.mcs_sync !== 1'b1 && n < 100) begin wait_n(1); n++; end
    wait_n(1);
    n_cmp++; if (bus.state !== 3'd5 || bus.mcs_sync !== 1'b1) begin n_bad++; $display("FAIL midrst_in_pulse: got state %0d mcs %b want 5 1", bus.state, bus.mcs_sync); end
    rst = 1'b1;
    wait_n(1);
    n_cmp++; if (bus.mcs_sync !== 1'b0 || bus.resetb_0 !== 1'b0 || bus.resetb_1 !== 1'b0) begin n_bad++; $display("FAIL midrst_pins: got mcs %b resetb %b%b want 0 00", bus.mcs_sync, bus.resetb_0, bus.resetb_1); end
    n_cmp++; if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got state %0d busy %b want 0 0", bus.state, bus.busy); end
    rst = 1'b0;
    ref_run = 1'b0;
    wait_n(2);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    cyc = 0; last_ref_e = 0; rise_cyc = 0; fall_cyc = 0; pulse_k = 0;
    ref_prev = 1'b0; mcs_prev = 1'b0;
    ref_run = 1'b0; ref_ph = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sync_req = 1'b0; bus.sync_count = 4'd0; bus.ref_clk_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_no_sync();
    test_full_with_syncs();
    test_timeout();
    test_simultaneous();
    test_edge_at_expiry();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
